// File: rtl/fifo18_to_gmii.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fifo18_to_gmii
//
// Drains 18-bit FIFO words (two bytes per word) onto a GMII transmit
// interface. Each frame is sent as a preamble, an SFD and then the payload
// bytes, high byte first. The block applies an inter-frame gap after every
// frame. A FIFO underrun in the middle of a frame is signalled with one
// tx_er cycle, and the rest of that frame is flushed from the FIFO.
//
// FIFO word layout:
//   [17]   high byte valid. A word with this bit clear is a frame delimiter.
//   [16]   low byte valid.
//   [15:8] high byte, sent first.
//   [7:0]  low byte.
//
// Parameters
//   Ifg       inter-frame gap in gmii_tx_clk cycles (1..31)
//   Preamble  number of 0x55 bytes sent before the SFD (1..7)
//
// Ports
//   gmii_tx_clk     in   the only clock; all state changes on its rising edge
//   sys_rst_n       in   asynchronous reset, active low
//   dout[17:0]      in   FIFO read data, valid the cycle after rd_en
//   empty           in   FIFO empty flag
//   rd_en           out  FIFO read strobe; never asserted while empty is high
//   rd_clk          out  FIFO read clock (the same net as gmii_tx_clk)
//   gmii_tx_en      out  GMII transmit enable (registered)
//   gmii_tx_er      out  GMII transmit error (registered); high only in ABORT
//   gmii_txd[7:0]   out  GMII transmit data (registered)
//   frame_count     out  frames completed without error; wraps at 0xFF
//   underrun_count  out  frames aborted by an underrun; wraps at 0xFF
// -----------------------------------------------------------------------------
module fifo18_to_gmii #(
  parameter logic [4:0] Ifg      = 5'd12,
  parameter logic [2:0] Preamble = 3'd7
) (
  input  logic        gmii_tx_clk,
  input  logic        sys_rst_n,
  input  logic [17:0] dout,
  input  logic        empty,
  output logic        rd_en,
  output logic        rd_clk,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic [7:0]  gmii_txd,
  output logic [7:0]  frame_count,
  output logic [7:0]  underrun_count
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_PREAMBLE = 4'd2;
  localparam logic [3:0] S_SFD      = 4'd3;
  localparam logic [3:0] S_DATAH    = 4'd4;
  localparam logic [3:0] S_DATAL    = 4'd5;
  localparam logic [3:0] S_ABORT    = 4'd6;
  localparam logic [3:0] S_DROP     = 4'd7;
  localparam logic [3:0] S_GAP      = 4'd8;

  logic [3:0]  state;
  logic [3:0]  state_nxt;
  // Only the byte-valid bit [16] and the payload are kept. The frame bit [17]
  // is always checked on dout in the cycle the word arrives.
  logic [16:0] word_buf;
  logic [16:0] word_buf_nxt;
  logic [4:0]  cnt;
  logic [4:0]  cnt_nxt;
  logic        rd_req;
  logic        rd_vld_p1;   // a read was issued last cycle, so dout is valid now
  logic        frame_done;
  logic        underrun;

  // GMII output decode for the state being entered. Because the outputs are
  // registered on the same edge as the state, they line up with the state.
  function automatic logic tx_en_of(input logic [3:0] s);
    return (s == S_PREAMBLE) || (s == S_SFD) || (s == S_DATAH) ||
           (s == S_DATAL) || (s == S_ABORT);
  endfunction

  function automatic logic [7:0] txd_of(input logic [3:0] s, input logic [15:0] w);
    logic [7:0] d;
    case (s)
      S_PREAMBLE: d = 8'h55;
      S_SFD:      d = 8'hD5;
      S_DATAH:    d = w[15:8];
      S_DATAL:    d = w[7:0];
      default:    d = 8'h00;
    endcase
    return d;
  endfunction

  assign rd_clk = gmii_tx_clk;

  // The read strobe is combinational, so the word is returned in the very
  // next state. This is what gives the DATAH/DATAL rate of one word every
  // two cycles. Gating with the reset keeps the FIFO untouched during reset.
  assign rd_en = rd_req & sys_rst_n;

  always_comb begin
    state_nxt    = state;
    word_buf_nxt = word_buf;
    cnt_nxt      = cnt;
    rd_req       = 1'b0;
    frame_done   = 1'b0;
    underrun     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          rd_req    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        // Delimiter words left over from a previous frame are dropped here.
        word_buf_nxt = dout[16:0];
        if (dout[17]) begin
          state_nxt = S_PREAMBLE;
          cnt_nxt   = {2'b00, Preamble} - 5'd1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_PREAMBLE: begin
        if (cnt == 5'd0) begin
          state_nxt = S_SFD;
        end else begin
          cnt_nxt = cnt - 5'd1;
        end
      end
      S_SFD: begin
        state_nxt = S_DATAH;
      end
      S_DATAH: begin
        if (word_buf[16]) begin
          // Fetch the next word while the low byte is on the wire. If the
          // FIFO is empty now, DATAL finds no data and the frame aborts.
          rd_req    = !empty;
          state_nxt = S_DATAL;
        end else begin
          frame_done = 1'b1;
          state_nxt  = S_GAP;
          cnt_nxt    = Ifg - 5'd1;
        end
      end
      S_DATAL: begin
        if (rd_vld_p1) begin
          word_buf_nxt = dout[16:0];
          if (dout[17]) begin
            state_nxt = S_DATAH;
          end else begin
            frame_done = 1'b1;
            state_nxt  = S_GAP;
            cnt_nxt    = Ifg - 5'd1;
          end
        end else begin
          state_nxt = S_ABORT;
        end
      end
      S_ABORT: begin
        underrun  = 1'b1;
        state_nxt = S_DROP;
      end
      S_DROP: begin
        // Read one word per cycle until a delimiter arrives. No further read
        // is issued in the cycle the delimiter is seen, so nothing after the
        // delimiter is taken from the FIFO.
        if (rd_vld_p1 && !dout[17]) begin
          state_nxt = S_GAP;
          cnt_nxt   = Ifg - 5'd1;
        end else begin
          rd_req = !empty;
        end
      end
      S_GAP: begin
        if (cnt == 5'd0) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - 5'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---- register stage: FSM state, word buffer, GMII outputs, counters ----
  always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= S_IDLE;
      word_buf       <= '0;
      cnt            <= '0;
      rd_vld_p1      <= 1'b0;
      gmii_tx_en     <= 1'b0;
      gmii_tx_er     <= 1'b0;
      gmii_txd       <= 8'h00;
      frame_count    <= 8'h00;
      underrun_count <= 8'h00;
    end else begin
      state      <= state_nxt;
      word_buf   <= word_buf_nxt;
      cnt        <= cnt_nxt;
      rd_vld_p1  <= rd_en;
      gmii_tx_en <= tx_en_of(state_nxt);
      gmii_tx_er <= (state_nxt == S_ABORT);
      gmii_txd   <= txd_of(state_nxt, word_buf_nxt[15:0]);
      if (frame_done) begin
        frame_count <= frame_count + 8'd1;
      end
      if (underrun) begin
        underrun_count <= underrun_count + 8'd1;
      end
    end
  end

endmodule

// File: doc/fifo18_to_gmii.md
FIFO18_TO_GMII -- requirements
Module: fifo18_to_gmii

Interface
REQ-001 Parameter Ifg, default 5'd12, SHALL set the inter-frame gap in gmii_tx_clk cycles (legal 1..31).
REQ-002 Parameter Preamble, default 3'd7, SHALL set the number of 0x55 bytes before the SFD (legal 1..7).
REQ-003 gmii_tx_clk  in  1  SHALL be the only clock; all state updates on its rising edge.
REQ-004 sys_rst_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 dout  in  18  SHALL be the FIFO read data: [17] high byte valid, [16] low byte valid, [15:8] high byte (sent first), [7:0] low byte; a word with [17]=0 is a frame delimiter.
REQ-006 empty  in  1  SHALL be the FIFO empty flag.
REQ-007 rd_en  out  1  SHALL be the FIFO read strobe; dout is valid the cycle after rd_en.
REQ-008 rd_clk  out  1  SHALL equal gmii_tx_clk.
REQ-009 gmii_tx_en, gmii_tx_er  out  1 each; gmii_txd  out  8  SHALL be the GMII transmit outputs, all registered.
REQ-010 frame_count  out  8  SHALL count frames completed without error, wrapping 0xFF->0x00.
REQ-011 underrun_count  out  8  SHALL count aborted frames, wrapping 0xFF->0x00.

Function
REQ-012 States: IDLE, FETCH, PREAMBLE, SFD, DATAH, DATAL, ABORT, DROP, GAP.
REQ-013 IDLE: tx_en=0, tx_er=0, txd=0x00; if !empty, assert rd_en and go to FETCH.
REQ-014 FETCH: capture dout into word buffer; [17]=1 -> PREAMBLE with counter=Preamble; [17]=0 -> discard and return to IDLE.
REQ-015 PREAMBLE: tx_en=1, txd=0x55 for exactly Preamble cycles, then SFD.
REQ-016 SFD: tx_en=1, txd=0xD5 for one cycle, then DATAH.
REQ-017 DATAH: tx_en=1, txd=buffer[15:8]; if buffer[16]=1, assert rd_en when !empty and go to DATAL; if buffer[16]=0, go to GAP and increment frame_count.
REQ-018 DATAL: tx_en=1, txd=buffer[7:0]; capture dout if a read was issued in DATAH.
REQ-019 On leaving DATAL with a read issued: captured word [17]=1 -> DATAH; [17]=0 -> GAP, frame_count+1.
REQ-020 On leaving DATAL with no read issued (empty in DATAH) -> ABORT.
REQ-021 ABORT: one cycle, tx_en=1, tx_er=1, txd=0x00; underrun_count+1; then DROP.
REQ-022 DROP: tx_en=0; read and discard FIFO words whenever !empty until a word with [17]=0 is received, then GAP.
REQ-023 GAP: tx_en=0, txd=0x00, rd_en=0 for exactly Ifg cycles, then IDLE.
REQ-024 Steady-state throughput SHALL be one FIFO word per two cycles; rd_en SHALL never be asserted while empty=1.
REQ-025 Extra delimiter words (e.g. receiver-side gap words) in IDLE SHALL be consumed silently via FETCH.
REQ-026 gmii_tx_er SHALL be 1 only in ABORT.

Reset
REQ-027 While sys_rst_n=0: state=IDLE; rd_en, gmii_tx_en, gmii_tx_er =0; gmii_txd=0x00; frame_count, underrun_count =0x00; buffer=0.
REQ-028 Reset asserted mid-frame SHALL drop tx_en immediately (asynchronously) with no error cycle; after release the block starts in IDLE and the remainder of the interrupted frame is read as a new frame.

Verification
REQ-029 FIFO holds {2'b11,0xAA,0xBB},{2'b11,0xCC,0xDD},18'h0 -> tx_en for 7x55,D5,AA,BB,CC,DD (12 cycles), then 12 idle cycles; frame_count=1.
REQ-030 Odd frame {2'b11,0x01,0x02},{2'b10,0x03,0x00},18'h0,18'h0 -> data 01,02,03 then GAP; both delimiter words consumed; frame_count=1.
REQ-031 Underrun: first word {2'b11,0x11,0x22}, second word pushed 5 cycles late -> 7x55,D5,11,22, one tx_er cycle, late words dropped through delimiter; underrun_count=1, frame_count=0.
REQ-032 Back-to-back: two 64-byte frames pre-loaded -> exactly Ifg=12 idle cycles plus 2 FETCH/IDLE cycles between frames; frame_count=2.
REQ-033 Assert sys_rst_n=0 during a DATAL cycle -> tx_en=0 within the same cycle, both counters 0x00; after release no tx_er cycle is produced.
REQ-034 Send 256 frames -> frame_count wraps to 0x00.
